sr_lock_arbiter: RTL and testbench



---
 rtl/sr_arb_pkg.sv | 27 ++
 rtl/sr_lock_arbiter_rr_pick.sv | 28 ++
 rtl/sr_lock_arbiter.sv | 108 ++++++++++
 tb/tb_sr_lock_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sr_arb_pkg.sv
// Shared types and helpers for the SR-lock round-robin arbiter.
// FSM state encoding, default sizing and a one-hot builder.
package sr_arb_pkg;

  localparam int NREQ_DEF    = 4;
  localparam int TIMEOUT_DEF = 16;
  localparam int NREQ_MAX    = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWNED   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Bit idx set when idx lies in 0..n-1, zero otherwise.
  function automatic logic [NREQ_MAX-1:0] onehot(
    input int idx,
    input int n
  );
    logic [NREQ_MAX-1:0] v;
    for (int i = 0; i < NREQ_MAX; i++) begin
      v[i] = (i == idx) && (i < n);
    end
    return v;
  endfunction

endpackage

// File: rtl/sr_lock_arbiter_rr_pick.sv
// Round-robin search: first set pend bit after ptr, wrapping mod NREQ.
// Ports: pend, ptr in; valid (any pending), idx (winner) out.
module rr_pick
  import sr_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] pend,
  input  logic [IDW-1:0]  ptr,
  output logic            valid,
  output logic [IDW-1:0]  idx
);

  int j;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    valid = |pend;
    idx   = '0;
    j     = 0;
    for (int k = NREQ; k >= 1; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (pend[j]) idx = IDW'(j);
    end
  end

endmodule

// File: rtl/sr_lock_arbiter.sv
// Lock-style round-robin arbiter with SR pending flags and hold timeout.
// Ports: clk, rst_n, req_set/req_clr/rel in; pend, grant, owner_id, busy, timeout_evt out.
module sr_lock_arbiter
  import sr_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int IDW     = $clog2(NREQ),
  parameter int CW      = $clog2(TIMEOUT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_set,
  input  logic [NREQ-1:0] req_clr,
  input  logic [NREQ-1:0] rel,
  output logic [NREQ-1:0] pend,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  owner_id,
  output logic            busy,
  output logic            timeout_evt
);

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [IDW-1:0]        ptr;

  logic                  pick_vld;
  logic [IDW-1:0]        pick_idx;
  logic [NREQ_MAX-1:0]   oh_w;
  logic [NREQ-1:0]       pick_oh;
  logic                  pick_ok;
  logic                  take;
  logic                  own_rel;
  logic                  at_limit;
  logic [NREQ-1:0]       pend_nxt;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .pend  (pend),
    .ptr   (ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  assign oh_w    = onehot(int'(pick_idx), NREQ);
  assign pick_oh = oh_w[NREQ-1:0];
  // An empty one-hot means the index fell outside 0..NREQ-1.
  assign pick_ok = pick_vld & (|oh_w);

  assign take     = (state == IDLE) && pick_ok;
  assign own_rel  = rel[owner_id];
  assign at_limit = (cnt == CW'(TIMEOUT - 1));

  assign busy        = (state != IDLE);
  // Forced revoke only; an owner release on the same cycle wins.
  assign timeout_evt = (state == OWNED) && at_limit && !own_rel;

  // SR flag: lone set/clear act, both or neither hold; a grant clears.
  always_comb begin
    pend_nxt = pend;
    for (int i = 0; i < NREQ; i++) begin
      if (req_set[i] && !req_clr[i]) pend_nxt[i] = 1'b1;
      else if (!req_set[i] && req_clr[i]) pend_nxt[i] = 1'b0;
      if (take && pick_oh[i]) pend_nxt[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= IDW'(NREQ - 1);
      owner_id <= '0;
      grant    <= '0;
      pend     <= '0;
    end else begin
      pend <= pend_nxt;
      unique case (state)
        IDLE: begin
          if (pick_ok) begin
            state    <= OWNED;
            grant    <= pick_oh;
            owner_id <= pick_idx;
            cnt      <= '0;
          end
        end
        OWNED: begin
          if (!at_limit) cnt <= cnt + 1'b1;
          if (own_rel || at_limit) begin
            state <= RELEASE;
            grant <= '0;
          end
        end
        RELEASE: begin
          ptr   <= owner_id;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_lock_arbiter.sv
// Directed self-checking bench for sr_lock_arbiter (NREQ=4, TIMEOUT=16).
// Linear stimulus; immediate assertions at each check point.
module tb_sr_lock_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_set;
  logic [3:0] req_clr;
  logic [3:0] rel;
  logic [3:0] pend;
  logic [3:0] grant;
  logic [1:0] owner_id;
  logic       busy;
  logic       timeout_evt;

  int errs;
  int checks;

  sr_lock_arbiter #(
    .NREQ    (4),
    .TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_set     (req_set),
    .req_clr     (req_clr),
    .rel         (rel),
    .pend        (pend),
    .grant       (grant),
    .owner_id    (owner_id),
    .busy        (busy),
    .timeout_evt (timeout_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  int order [5];
  int o;
  int gcnt;
  int ecnt;
  int epos;

  initial begin
    errs    = 0;
    checks  = 0;
    order   = '{0, 1, 2, 3, 0};
    rst_n   = 1'b0;
    req_set = '0;
    req_clr = '0;
    rel     = '0;
    #1;
    chk("rst_pend", pend, 0);
    chk("rst_grant", grant, 0);
    chk("rst_owner", owner_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tevt", timeout_evt, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // single request, 2-edge latency
    req_set = 4'b0001;
    tick();
    req_set = '0;
    chk("lat_pend", pend, 4'b0001);
    chk("lat_nogrant", grant, 0);
    tick();
    chk("lat_grant", grant, 4'b0001);
    chk("lat_owner", owner_id, 0);
    chk("lat_busy", busy, 1);
    chk("lat_pendclr", pend, 0);

    // non-owner release ignored, then owner release
    rel = 4'b0010;
    tick();
    chk("nonown_rel", grant, 4'b0001);
    rel = 4'b0001;
    chk("rel_no_tevt", timeout_evt, 0);
    tick();
    rel = '0;
    chk("rel_state", {busy, grant}, 5'b1_0000);
    tick();
    chk("idle_state", {busy, grant}, 5'b0_0000);
    chk("owner_hold", owner_id, 0);

    // reset to restore ptr so requester 0 leads the rotation
    #3;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    req_set = 4'b1111;
    tick();
    req_set = '0;
    chk("rr_preload", pend, 4'b1111);
    tick();
    for (int k = 0; k < 5; k++) begin
      o = order[k];
      chk("rr_grant", grant, 32'(1 << o));
      chk("rr_owner", owner_id, o);
      if (k == 1) req_set = 4'b0001;
      tick();
      req_set = '0;
      tick();
      chk("rr_hold", grant, 32'(1 << o));
      rel = 4'(1 << o);
      tick();
      rel = '0;
      chk("rr_rel", {busy, grant}, 5'b1_0000);
      tick();
      chk("rr_idle", {busy, grant}, 5'b0_0000);
      if (k < 4) tick();
    end

    // timeout: owner 1 never releases
    req_set = 4'b0110;
    tick();
    req_set = '0;
    chk("to_pend", pend, 4'b0110);
    tick();
    gcnt = 0;
    ecnt = 0;
    epos = -1;
    for (int i = 0; i < 16; i++) begin
      if (grant == 4'b0010) gcnt++;
      if (timeout_evt) begin
        ecnt++;
        epos = i;
      end
      tick();
    end
    chk("to_gcnt", gcnt, 16);
    chk("to_ecnt", ecnt, 1);
    chk("to_epos", epos, 15);
    chk("to_rel", {busy, grant}, 5'b1_0000);
    chk("to_tevt_low", timeout_evt, 0);
    tick();
    tick();
    chk("to_next", grant, 4'b0100);
    chk("to_next_pend", pend, 0);

    // SR behaviour on owner 2's own pend bit
    req_set = 4'b0100;
    req_clr = 4'b0100;
    tick();
    chk("sr_both0", pend[2], 0);
    req_clr = '0;
    tick();
    chk("sr_set", pend[2], 1);
    req_clr = 4'b0100;
    tick();
    chk("sr_both1", pend[2], 1);
    req_set = '0;
    tick();
    req_clr = '0;
    chk("sr_clr", pend[2], 0);

    // release exactly on the timeout cycle is a normal release
    repeat (11) tick();
    chk("rt_grant", grant, 4'b0100);
    chk("rt_tevt", timeout_evt, 1);
    rel = 4'b0100;
    #1;
    chk("rt_tevt_rel", timeout_evt, 0);
    tick();
    rel = '0;
    chk("rt_state", {busy, grant, timeout_evt}, 6'b1_0000_0);
    tick();

    // async reset mid-ownership
    req_set = 4'b1000;
    tick();
    req_set = '0;
    tick();
    chk("ar_grant3", grant, 4'b1000);
    req_set = 4'b0001;
    tick();
    req_set = '0;
    chk("ar_pend0", pend, 4'b0001);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_grant", grant, 0);
    chk("ar_busy", busy, 0);
    chk("ar_pend", pend, 0);
    chk("ar_owner", owner_id, 0);
    tick();
    rst_n = 1'b1;
    req_set = 4'b1001;
    tick();
    req_set = '0;
    chk("ar_pend2", pend, 4'b1001);
    tick();
    chk("ar_tie0", grant, 4'b0001);
    chk("ar_left3", pend, 4'b1000);
    rel = 4'b0001;
    tick();
    rel = '0;
    tick();
    tick();
    chk("ar_then3", grant, 4'b1000);
    chk("ar_owner3", owner_id, 3);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
